// File: rtl/mem_responder_sram.sv
// Memory-side responder for the core request/grant bus: wait-state FSM, byte-strobed word array, 1-cycle registered response.
// Optional random stall insertion is enabled with `define MEM_RESPONDER_RAND_STALL_EN.
module mem_responder_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        f_clk,
  input  logic        g_reset,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [7:0]  mem_strb,
  input  logic [63:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_err,
  output logic [63:0] mem_rdata
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] LIMIT_ADDR = BASE_ADDR + (64'(DEPTH_WORDS) << 3);

  typedef enum logic {S_IDLE, S_STALL} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [4:0]  wait_w;

  logic [63:0]      addr_word;
  logic [63:0]      addr_off;
  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic             addr_unused;

  logic        hs;
  logic        wr_en;
  logic        rd_en;
  logic        resp_err_reg;
  logic        resp_rd_reg;
  logic [7:0]  rd_byte_reg [8];
  logic [63:0] rd_word;

  // ------------------------------------------------------------------
  // Wait-state count for a new request
  // ------------------------------------------------------------------
`ifdef MEM_RESPONDER_RAND_STALL_EN
  logic [15:0] lfsr_reg, lfsr_next;

  // Fibonacci LFSR, taps 16,14,13,11; free-running so stalls vary per request
  always_comb begin
    lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  end

  always_ff @(posedge f_clk) begin
    if (g_reset) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign wait_w = 5'(WAIT_CYCLES) + {3'b000, lfsr_reg[1:0]};
`else
  localparam logic [15:0] LFSR_SEED_UNUSED = LFSR_SEED;
  assign wait_w = 5'(WAIT_CYCLES);
`endif

  // ------------------------------------------------------------------
  // Address decode: word-aligned, no wrap around the top of the range
  // ------------------------------------------------------------------
  assign addr_word   = {mem_addr[63:3], 3'b000};
  assign in_range    = (addr_word >= BASE_ADDR) && (addr_word < LIMIT_ADDR);
  assign addr_off    = addr_word - BASE_ADDR;
  assign word_idx    = addr_off[IDX_W+2:3];
  assign addr_unused = ^{mem_addr[2:0], addr_off[2:0], addr_off[63:IDX_W+3]};

  // ------------------------------------------------------------------
  // Wait-state FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge f_clk) begin
    if (g_reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (mem_req && (wait_w != 5'd0)) begin
          state_next = S_STALL;
          cnt_next   = wait_w - 5'd1;
        end
      end
      S_STALL: begin
        // Dropping req mid-stall abandons the request without a handshake
        if (!mem_req) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg != 5'd0) begin
          cnt_next   = cnt_reg - 5'd1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic: gnt is combinational from req, never high without req
  always_comb begin
    mem_gnt = 1'b0;
    case (state_reg)
      S_IDLE:  mem_gnt = mem_req && (wait_w == 5'd0);
      S_STALL: mem_gnt = mem_req && (cnt_reg == 5'd0);
      default: mem_gnt = 1'b0;
    endcase
    if (g_reset) begin
      mem_gnt = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Handshake qualification and registered response flags
  // ------------------------------------------------------------------
  assign hs    = mem_req && mem_gnt;
  assign wr_en = hs && mem_wen && in_range;
  assign rd_en = hs && !mem_wen && in_range;

  always_ff @(posedge f_clk) begin
    if (g_reset) begin
      resp_err_reg <= 1'b0;
      resp_rd_reg  <= 1'b0;
    end else begin
      resp_err_reg <= hs && !in_range;
      resp_rd_reg  <= rd_en;
    end
  end

  // ------------------------------------------------------------------
  // Word array split into byte lanes so each strobe maps to its own RAM
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH_WORDS];

      always_ff @(posedge f_clk) begin
        if (wr_en && mem_strb[gi]) begin
          mem_lane[word_idx] <= mem_wdata[8*gi +: 8];
        end
        if (rd_en) begin
          rd_byte_reg[gi] <= mem_lane[word_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_reg[gi];
    end
  endgenerate

  // Read register is masked so rdata is zero outside a read response
  assign mem_err   = resp_err_reg;
  assign mem_rdata = resp_rd_reg ? rd_word : 64'h0;

endmodule

// File: tb/tb_mem_responder_sram.sv
// Bench for mem_responder_sram: three instances (0, 3 and 5 wait states) driven by directed steps
// with a scoreboard queue of expected responses and a byte-accurate reference memory.
module tb_mem_responder_sram;

  localparam logic [63:0] BASE0 = 64'h0;
  localparam logic [63:0] BASE1 = 64'h1000;
  localparam logic [63:0] BASE2 = 64'h2000;
  localparam int          DEP0  = 1024;
  localparam int          DEP1  = 256;
  localparam int          DEP2  = 64;
  localparam int          WT0   = 0;
  localparam int          WT1   = 3;
  localparam int          WT2   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [3];
  logic [63:0] addr  [3];
  logic        wen   [3];
  logic [7:0]  strb  [3];
  logic [63:0] wdata [3];
  logic        gnt   [3];
  logic        err   [3];
  logic [63:0] rdata [3];
  bit          pend  [3];

  int n_chk  = 0;
  int n_pass = 0;

  logic [64:0] expq [$];
  logic [63:0] model [longint];

  initial forever #5 clk = ~clk;

  mem_responder_sram #(.DEPTH_WORDS(DEP0), .BASE_ADDR(BASE0), .WAIT_CYCLES(WT0)) u_w0 (
    .f_clk(clk), .g_reset(rst), .mem_req(req[0]), .mem_addr(addr[0]), .mem_wen(wen[0]),
    .mem_strb(strb[0]), .mem_wdata(wdata[0]), .mem_gnt(gnt[0]), .mem_err(err[0]), .mem_rdata(rdata[0]));

  mem_responder_sram #(.DEPTH_WORDS(DEP1), .BASE_ADDR(BASE1), .WAIT_CYCLES(WT1)) u_w3 (
    .f_clk(clk), .g_reset(rst), .mem_req(req[1]), .mem_addr(addr[1]), .mem_wen(wen[1]),
    .mem_strb(strb[1]), .mem_wdata(wdata[1]), .mem_gnt(gnt[1]), .mem_err(err[1]), .mem_rdata(rdata[1]));

  mem_responder_sram #(.DEPTH_WORDS(DEP2), .BASE_ADDR(BASE2), .WAIT_CYCLES(WT2)) u_w5 (
    .f_clk(clk), .g_reset(rst), .mem_req(req[2]), .mem_addr(addr[2]), .mem_wen(wen[2]),
    .mem_strb(strb[2]), .mem_wdata(wdata[2]), .mem_gnt(gnt[2]), .mem_err(err[2]), .mem_rdata(rdata[2]));

  function automatic logic [63:0] base_of(input int d);
    return (d == 0) ? BASE0 : (d == 1) ? BASE1 : BASE2;
  endfunction

  function automatic logic [63:0] depth_of(input int d);
    return (d == 0) ? 64'(DEP0) : (d == 1) ? 64'(DEP1) : 64'(DEP2);
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? WT0 : (d == 1) ? WT1 : WT2;
  endfunction

  function automatic bit dly_ok(input int d, input int dly);
`ifdef MEM_RESPONDER_RAND_STALL_EN
    return (dly >= wait_of(d)) && (dly <= wait_of(d) + 3);
`else
    return dly == wait_of(d);
`endif
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference model: compute the response this request must produce and queue it
  task automatic push_exp(input int d, input logic w, input logic [63:0] a,
                          input logic [7:0] s, input logic [63:0] dat);
    logic [63:0] aw;
    logic [63:0] cur;
    longint      key;
    aw = {a[63:3], 3'b000};
    if (aw < base_of(d) || aw >= base_of(d) + (depth_of(d) << 3)) begin
      expq.push_back({1'b1, 64'h0});
    end else begin
      key = (longint'(d) << 32) | longint'((aw - base_of(d)) >> 3);
      cur = model.exists(key) ? model[key] : 64'hx;
      if (w) begin
        for (int i = 0; i < 8; i++)
          if (s[i]) cur[8*i +: 8] = dat[8*i +: 8];
        model[key] = cur;
        expq.push_back({1'b0, 64'h0});
      end else begin
        expq.push_back({1'b0, cur});
      end
    end
  endtask

  task automatic take_resp(input int d);
    logic [64:0] e;
    if (expq.size() == 0) begin
      check("scoreboard_empty", 65'(expq.size()), 65'd1);
    end else begin
      e = expq.pop_front();
      check("resp", {err[d], rdata[d]}, e);
    end
    pend[d] = 1'b0;
  endtask

  // Precondition: called just after a posedge. Returns with req dropped, just after a posedge.
  task automatic txn(input int d, input logic w, input logic [63:0] a, input logic [7:0] s,
                     input logic [63:0] dat, output int dly);
    bit got;
    got = 1'b0;
    push_exp(d, w, a, s, dat);
    req[d] = 1'b1; wen[d] = w; addr[d] = a; strb[d] = s; wdata[d] = dat;
    dly = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pend[d]) take_resp(d);
      else check("idle_resp", {err[d], rdata[d]}, 65'h0);
      if (gnt[d]) begin
        got = 1'b1;
        break;
      end
      dly++;
      @(posedge clk); #1;
    end
    if (!got) begin
      check("gnt_timeout", 65'(got), 65'd1);
      void'(expq.pop_back());
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      pend[d] = 1'b1;
    end
    req[d] = 1'b0;
  endtask

  // Consume an outstanding response and confirm it lasts only one cycle
  task automatic flush(input int d);
    if (pend[d]) begin
      @(negedge clk);
      take_resp(d);
      @(posedge clk); #1;
      @(negedge clk);
      check("resp_one_cycle", {err[d], rdata[d]}, 65'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly;
    logic [63:0] a;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; addr[d] = '0; wen[d] = 1'b0; strb[d] = '0; wdata[d] = '0; pend[d] = 1'b0;
    end
    req[0] = 1'b1;  // gnt must stay low under reset even with zero wait states
    repeat (3) begin
      @(negedge clk);
      check("rst_gnt0", 65'(gnt[0]), 65'd0);
      check("rst_resp0", {err[0], rdata[0]}, 65'h0);
      @(posedge clk); #1;
    end
    req[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero wait states: write then back-to-back read
    txn(0, 1'b1, 64'h10, 8'hFF, 64'h1122334455667788, dly);
    check("w0_write_dly", 65'(dly_ok(0, dly)), 65'd1);
    txn(0, 1'b0, 64'h10, 8'h00, 64'h0, dly);
    check("w0_read_dly", 65'(dly_ok(0, dly)), 65'd1);
    flush(0);

    // Partial strobe and strobe-free write on word 0
    txn(0, 1'b1, 64'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, dly);
    txn(0, 1'b1, 64'h0, 8'h0F, 64'h0, dly);
    txn(0, 1'b0, 64'h0, 8'h00, 64'h0, dly);
    txn(0, 1'b1, 64'h4, 8'h00, 64'h5A5A_5A5A_5A5A_5A5A, dly);
    txn(0, 1'b0, 64'h7, 8'h00, 64'h0, dly);
    flush(0);

    // Three wait states, range boundaries, out-of-range write leaves word 0 intact
    txn(1, 1'b1, BASE1, 8'hFF, 64'hA5A5_0000_1234_5678, dly);
    check("w3_dly", 65'(dly_ok(1, dly)), 65'd1);
    txn(1, 1'b1, BASE1 + 64'h7F8, 8'hFF, 64'hC0DE_C0DE_0BAD_F00D, dly);
    txn(1, 1'b0, BASE1 + 64'h800, 8'h00, 64'h0, dly);
    check("w3_oor_dly", 65'(dly_ok(1, dly)), 65'd1);
    txn(1, 1'b1, BASE1 + 64'h800, 8'hFF, 64'hBBBB_BBBB_BBBB_BBBB, dly);
    txn(1, 1'b1, BASE1 - 64'h8, 8'hFF, 64'hCCCC_CCCC_CCCC_CCCC, dly);
    txn(1, 1'b0, BASE1, 8'h00, 64'h0, dly);
    txn(1, 1'b0, BASE1 + 64'h7F8, 8'h00, 64'h0, dly);
    flush(1);

    // Abandoned request in STALL must not produce a grant
    req[1] = 1'b1; wen[1] = 1'b1; addr[1] = BASE1; strb[1] = 8'hFF; wdata[1] = 64'hDEAD;
    @(negedge clk);
    check("abandon_gnt", 65'(gnt[1]), 65'd0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    check("abandon_after", {gnt[1], err[1], rdata[1]}, 65'h0);
    @(posedge clk); #1;
    txn(1, 1'b0, BASE1, 8'h00, 64'h0, dly);
    check("abandon_full_wait", 65'(dly_ok(1, dly)), 65'd1);
    flush(1);

    // Reset during a five-cycle stall drops the write
    txn(2, 1'b1, BASE2 + 64'h8, 8'hFF, 64'h0123_4567_89AB_CDEF, dly);
    check("w5_dly", 65'(dly_ok(2, dly)), 65'd1);
    flush(2);
    req[2] = 1'b1; wen[2] = 1'b1; addr[2] = BASE2 + 64'h8; strb[2] = 8'hFF; wdata[2] = 64'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      check("stall_gnt0", 65'(gnt[2]), 65'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stall_rst", {gnt[2], err[2], rdata[2]}, 65'h0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    req[2] = 1'b0;
    @(negedge clk);
    check("post_rst", {gnt[2], err[2], rdata[2]}, 65'h0);
    @(posedge clk); #1;
    txn(2, 1'b0, BASE2 + 64'h8, 8'h00, 64'h0, dly);
    check("post_rst_dly", 65'(dly_ok(2, dly)), 65'd1);
    flush(2);

    // Random back-to-back traffic on the three-wait-state instance
    for (int i = 0; i < 16; i++) begin
      txn(1, 1'b1, BASE1 + 64'(i * 8), 8'hFF, {$urandom, $urandom}, dly);
      check("rand_init_dly", 65'(dly_ok(1, dly)), 65'd1);
    end
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = BASE1 + (64'(DEP1) << 3) + 64'($urandom_range(0, 15) * 8);
      else
        a = BASE1 + 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7));
      txn(1, 1'($urandom_range(0, 1)), a, 8'($urandom), {$urandom, $urandom}, dly);
      check("rand_dly", 65'(dly_ok(1, dly)), 65'd1);
    end
    flush(1);
    check("scoreboard_drained", 65'(expq.size()), 65'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
